alu_operand_issue: RTL and testbench

//  Producer side of the ALU input interface (op0/op1/alu_op) in the pipelined NAND CPU.

---
 rtl/alu_operand_issue_if.sv | 48 ++++
 rtl/alu_operand_issue.sv | 196 +++++++++++++++++++
 tb/tb_alu_operand_issue.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_issue_if.sv
// Decode / issue / writeback bundle between the decoder, the operand
// issue stage and the ALU. The slave modport is the issue stage's view.
interface alu_operand_issue_if #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 16,
    parameter int IMM_W    = 6
);
    localparam int REG_W = $clog2(NUM_REGS);

    // decoded instruction
    logic              dec_valid;
    logic              dec_ready;
    logic [2:0]        dec_op;
    logic [REG_W-1:0]  dec_rd;
    logic [REG_W-1:0]  dec_rs_a;
    logic [REG_W-1:0]  dec_rs_b;
    logic              dec_use_imm;
    logic [IMM_W-1:0]  dec_imm;

    // issue slot towards the ALU
    logic              iss_valid;
    logic              iss_ready;
    logic [DATA_W-1:0] op0;
    logic [DATA_W-1:0] op1;
    logic [2:0]        alu_op;
    logic [REG_W-1:0]  iss_rd;

    // writeback port
    logic              wb_valid;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;

    modport slave (
        input  dec_valid, dec_op, dec_rd, dec_rs_a, dec_rs_b, dec_use_imm, dec_imm,
        output dec_ready,
        output iss_valid, op0, op1, alu_op, iss_rd,
        input  iss_ready,
        input  wb_valid, wb_rd, wb_data
    );

    modport master (
        output dec_valid, dec_op, dec_rd, dec_rs_a, dec_rs_b, dec_use_imm, dec_imm,
        input  dec_ready,
        input  iss_valid, op0, op1, alu_op, iss_rd,
        output iss_ready,
        output wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/alu_operand_issue.sv
// Operand issue stage of the pipelined NAND CPU: holds the architectural
// register file, forwards same-cycle writeback data, blocks RAW/WAW hazards
// with a per-register scoreboard and registers one issue slot for the ALU.
module alu_operand_issue #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 16,
    parameter int IMM_W    = 6
) (
    input  logic               clk,
    input  logic               n_rst,
    alu_operand_issue_if.slave bus
);
    localparam int REG_W = $clog2(NUM_REGS);

    typedef enum logic [2:0] {
        OP_CL   = 3'd0,
        OP_CP   = 3'd1,
        OP_NAND = 3'd2,
        OP_LS   = 3'd3,
        OP_RS   = 3'd4,
        OP_EQ   = 3'd5,
        OP_NE   = 3'd6,
        OP_LI   = 3'd7
    } alu_op_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    alu_op_e           op;
    slot_state_e       slot_state;
    slot_state_e       slot_state_nxt;

    logic [DATA_W-1:0] rf [NUM_REGS];
    logic [NUM_REGS-1:0] sb;

    logic [REG_W-1:0]  src_a;
    logic [REG_W-1:0]  src_b;
    logic              use_a;
    logic              use_b;
    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] nxt_op0;
    logic [DATA_W-1:0] nxt_op1;

    logic [NUM_REGS-1:0] wb_onehot;
    logic [NUM_REGS-1:0] dec_onehot;
    logic [NUM_REGS-1:0] busy;
    logic              hazard;
    logic              slot_free;
    logic              dec_ready;
    logic              accept;

    logic [DATA_W-1:0] op0_q;
    logic [DATA_W-1:0] op1_q;
    logic [2:0]        alu_op_q;
    logic [REG_W-1:0]  iss_rd_q;

    assign op      = alu_op_e'(bus.dec_op);
    assign imm_ext = {{(DATA_W-IMM_W){1'b0}}, bus.dec_imm};

    // one-hot views of the writeback and destination registers
    always_comb begin
        wb_onehot  = '0;
        dec_onehot = '0;
        if (bus.wb_valid) begin
            wb_onehot[bus.wb_rd] = 1'b1;
        end
        dec_onehot[bus.dec_rd] = 1'b1;
    end

    // source register selection per operation class
    always_comb begin
        src_a = bus.dec_rs_a;
        src_b = bus.dec_rs_b;
        use_a = 1'b0;
        use_b = 1'b0;
        case (op)
            OP_CL: begin
            end
            OP_CP: begin
                use_a = 1'b1;
            end
            OP_LI: begin
                // LI patches one nibble of rd, so rd is also its read source
                src_a = bus.dec_rd;
                use_a = 1'b1;
            end
            default: begin
                use_a = 1'b1;
                use_b = !bus.dec_use_imm;
            end
        endcase
    end

    // register reads with same-cycle writeback forwarding
    always_comb begin
        val_a = rf[src_a];
        val_b = rf[src_b];
        if (bus.wb_valid && (bus.wb_rd == src_a)) begin
            val_a = bus.wb_data;
        end
        if (bus.wb_valid && (bus.wb_rd == src_b)) begin
            val_b = bus.wb_data;
        end
    end

    // operand values loaded into the slot on accept; unused operands are zero
    always_comb begin
        nxt_op0 = use_a ? val_a : '0;
        case (op)
            OP_CL, OP_CP: nxt_op1 = '0;
            OP_LI:        nxt_op1 = imm_ext;
            default:      nxt_op1 = bus.dec_use_imm ? imm_ext : val_b;
        endcase
    end

    // hazard detection: a writeback landing this cycle releases its register
    always_comb begin
        busy      = sb & ~wb_onehot;
        hazard    = busy[bus.dec_rd]
                  | (use_a & busy[src_a])
                  | (use_b & busy[src_b]);
        slot_free = (slot_state == SLOT_EMPTY) || bus.iss_ready;
        dec_ready = slot_free && !hazard && n_rst;
        accept    = bus.dec_valid && dec_ready;
    end

    // issue slot next-state
    always_comb begin
        slot_state_nxt = slot_state;
        case (slot_state)
            SLOT_EMPTY: begin
                if (accept) begin
                    slot_state_nxt = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (accept) begin
                    slot_state_nxt = SLOT_FULL;
                end else if (bus.iss_ready) begin
                    slot_state_nxt = SLOT_EMPTY;
                end
            end
            default: slot_state_nxt = SLOT_EMPTY;
        endcase
    end

    // issue slot state register
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            slot_state <= SLOT_EMPTY;
        end else begin
            slot_state <= slot_state_nxt;
        end
    end

    // issue slot payload, held while the ALU stalls
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            op0_q    <= '0;
            op1_q    <= '0;
            alu_op_q <= '0;
            iss_rd_q <= '0;
        end else if (accept) begin
            op0_q    <= nxt_op0;
            op1_q    <= nxt_op1;
            alu_op_q <= bus.dec_op;
            iss_rd_q <= bus.dec_rd;
        end
    end

    // register file and scoreboard; a new producer's set beats a writeback clear
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                rf[REG_W'(i)] <= '0;
            end
            sb <= '0;
        end else begin
            if (bus.wb_valid) begin
                rf[bus.wb_rd] <= bus.wb_data;
            end
            sb <= (sb & ~wb_onehot) | (accept ? dec_onehot : '0);
        end
    end

    assign bus.dec_ready = dec_ready;
    assign bus.iss_valid = (slot_state == SLOT_FULL);
    assign bus.op0       = op0_q;
    assign bus.op1       = op1_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.iss_rd    = iss_rd_q;
endmodule

// File: tb/tb_alu_operand_issue.sv
// Bench for alu_operand_issue: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a register/
// scoreboard model of the issue stage.
module tb_alu_operand_issue;
    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    alu_operand_issue_if #(.NUM_REGS(16), .DATA_W(16), .IMM_W(6)) bus ();

    alu_operand_issue #(.NUM_REGS(16), .DATA_W(16), .IMM_W(6)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] rf_m [16];
    logic [15:0] sb_m;
    logic        m_valid;
    logic [15:0] m_op0, m_op1;
    logic [2:0]  m_op;
    logic [3:0]  m_rd;
    bit          m_init = 1'b0;

    function automatic logic [15:0] m_read(input int r);
        if (bus.wb_valid && int'(bus.wb_rd) == r) return bus.wb_data;
        return rf_m[r];
    endfunction

    function automatic logic m_pend(input int r);
        return sb_m[r] && !(bus.wb_valid && int'(bus.wb_rd) == r);
    endfunction

    function automatic logic m_ready();
        logic h;
        int o, a, b, d;
        o = int'(bus.dec_op);
        a = int'(bus.dec_rs_a);
        b = int'(bus.dec_rs_b);
        d = int'(bus.dec_rd);
        h = m_pend(d);
        if (o == 1) h = h | m_pend(a);
        else if (o >= 2 && o <= 6) h = h | m_pend(a) | (!bus.dec_use_imm && m_pend(b));
        return n_rst && (!m_valid || bus.iss_ready) && !h;
    endfunction

    function automatic logic [15:0] m_exp_op0();
        int o;
        o = int'(bus.dec_op);
        if (o == 0) return 16'h0;
        if (o == 7) return m_read(int'(bus.dec_rd));
        return m_read(int'(bus.dec_rs_a));
    endfunction

    function automatic logic [15:0] m_exp_op1();
        int o;
        o = int'(bus.dec_op);
        if (o == 0 || o == 1) return 16'h0;
        if (o == 7 || bus.dec_use_imm) return {10'b0, bus.dec_imm};
        return m_read(int'(bus.dec_rs_b));
    endfunction

    always @(posedge clk) begin
        logic acc;
        logic [15:0] e0, e1;
        if (!n_rst) begin
            for (int i = 0; i < 16; i++) rf_m[i] = 16'h0;
            sb_m    = 16'h0;
            m_valid = 1'b0;
            m_op0   = 16'h0;
            m_op1   = 16'h0;
            m_op    = 3'd0;
            m_rd    = 4'd0;
            m_init  = 1'b1;
        end else if (m_init) begin
            acc = bus.dec_valid && m_ready();
            e0  = m_exp_op0();
            e1  = m_exp_op1();
            if (acc) begin
                m_valid = 1'b1;
                m_op0   = e0;
                m_op1   = e1;
                m_op    = bus.dec_op;
                m_rd    = bus.dec_rd;
            end else if (bus.iss_ready) begin
                m_valid = 1'b0;
            end
            if (bus.wb_valid) begin
                rf_m[int'(bus.wb_rd)] = bus.wb_data;
                sb_m[int'(bus.wb_rd)] = 1'b0;
            end
            if (acc) sb_m[int'(bus.dec_rd)] = 1'b1;
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_init) begin
            chk("iss_valid", {31'b0, bus.iss_valid}, {31'b0, m_valid});
            chk("dec_ready", {31'b0, bus.dec_ready}, {31'b0, m_ready()});
            chk("op0",       {16'b0, bus.op0},       {16'b0, m_op0});
            chk("op1",       {16'b0, bus.op1},       {16'b0, m_op1});
            chk("alu_op",    {29'b0, bus.alu_op},    {29'b0, m_op});
            chk("iss_rd",    {28'b0, bus.iss_rd},    {28'b0, m_rd});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.dec_valid = 1'b0;
        bus.wb_valid  = 1'b0;
    endtask

    task automatic set_dec(input int o, input int rd, input int a, input int b,
                           input logic ui, input logic [5:0] imm);
        bus.dec_valid   = 1'b1;
        bus.dec_op      = 3'(o);
        bus.dec_rd      = 4'(rd);
        bus.dec_rs_a    = 4'(a);
        bus.dec_rs_b    = 4'(b);
        bus.dec_use_imm = ui;
        bus.dec_imm     = imm;
    endtask

    task automatic set_wb(input int r, input logic [15:0] d);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 4'(r);
        bus.wb_data  = d;
    endtask

    task automatic do_wb(input int r, input logic [15:0] d);
        set_wb(r, d);
        cyc();
        bus.wb_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_rst           = 1'b0;
        bus.dec_valid   = 1'b0;
        bus.dec_op      = 3'd0;
        bus.dec_rd      = 4'd0;
        bus.dec_rs_a    = 4'd0;
        bus.dec_rs_b    = 4'd0;
        bus.dec_use_imm = 1'b0;
        bus.dec_imm     = 6'd0;
        bus.iss_ready   = 1'b1;
        bus.wb_valid    = 1'b0;
        bus.wb_rd       = 4'd0;
        bus.wb_data     = 16'h0;

        // 1: reset, then NAND r1,r2,r3 from a cleared regfile
        cyc();
        cyc();
        chk("t1_rst_valid", {31'b0, bus.iss_valid}, 32'd0);
        chk("t1_rst_ready", {31'b0, bus.dec_ready}, 32'd0);
        chk("t1_rst_op0",   {16'b0, bus.op0},       32'd0);
        n_rst = 1'b1;
        set_dec(2, 1, 2, 3, 1'b0, 6'd0);
        #1 chk("t1_ready", {31'b0, bus.dec_ready}, 32'd1);
        cyc();
        idle();
        chk("t1_valid",  {31'b0, bus.iss_valid}, 32'd1);
        chk("t1_op0",    {16'b0, bus.op0},       32'h0);
        chk("t1_op1",    {16'b0, bus.op1},       32'h0);
        chk("t1_aluop",  {29'b0, bus.alu_op},    32'd2);
        chk("t1_issrd",  {28'b0, bus.iss_rd},    32'd1);
        do_wb(1, 16'h0);

        // 2: same-cycle forward, then regfile readback
        set_wb(2, 16'h00F0);
        set_dec(1, 4, 2, 0, 1'b0, 6'd0);
        #1 chk("t2_ready", {31'b0, bus.dec_ready}, 32'd1);
        cyc();
        idle();
        chk("t2_fwd_op0", {16'b0, bus.op0},    32'h00F0);
        chk("t2_aluop",   {29'b0, bus.alu_op}, 32'd1);
        chk("t2_issrd",   {28'b0, bus.iss_rd}, 32'd4);
        set_dec(1, 8, 2, 0, 1'b0, 6'd0);
        cyc();
        idle();
        chk("t2_readback", {16'b0, bus.op0}, 32'h00F0);
        do_wb(4, 16'h0);
        do_wb(8, 16'h0);

        // 3: RAW stall released by a same-cycle writeback
        set_dec(2, 5, 1, 1, 1'b0, 6'd0);
        cyc();
        set_dec(1, 6, 5, 0, 1'b0, 6'd0);
        #1 chk("t3_stall0", {31'b0, bus.dec_ready}, 32'd0);
        cyc();
        chk("t3_stall1", {31'b0, bus.dec_ready}, 32'd0);
        cyc();
        chk("t3_stall2", {31'b0, bus.dec_ready}, 32'd0);
        set_wb(5, 16'h1234);
        #1 chk("t3_release", {31'b0, bus.dec_ready}, 32'd1);
        cyc();
        idle();
        chk("t3_op0",   {16'b0, bus.op0},    32'h1234);
        chk("t3_issrd", {28'b0, bus.iss_rd}, 32'd6);
        do_wb(6, 16'h0);

        // 4: backpressure holds the slot for 3 cycles
        bus.iss_ready = 1'b0;
        set_dec(1, 9, 2, 0, 1'b0, 6'd0);
        cyc();
        set_dec(1, 10, 2, 0, 1'b0, 6'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_ready", {31'b0, bus.dec_ready}, 32'd0);
            chk("t4_op0",   {16'b0, bus.op0},       32'h00F0);
            chk("t4_aluop", {29'b0, bus.alu_op},    32'd1);
            chk("t4_issrd", {28'b0, bus.iss_rd},    32'd9);
            cyc();
        end
        bus.iss_ready = 1'b1;
        #1 chk("t4_release", {31'b0, bus.dec_ready}, 32'd1);
        cyc();
        idle();
        chk("t4_next_valid", {31'b0, bus.iss_valid}, 32'd1);
        chk("t4_next_issrd", {28'b0, bus.iss_rd},    32'd10);
        do_wb(9, 16'h0);
        do_wb(10, 16'h0);

        // 5: LI reads rd, zero-extends the immediate, and WAW-stalls
        do_wb(7, 16'hABCD);
        set_dec(7, 7, 0, 0, 1'b0, 6'b10_0101);
        #1 chk("t5_ready", {31'b0, bus.dec_ready}, 32'd1);
        cyc();
        idle();
        chk("t5_op0",   {16'b0, bus.op0},    32'hABCD);
        chk("t5_op1",   {16'b0, bus.op1},    32'h0025);
        chk("t5_aluop", {29'b0, bus.alu_op}, 32'd7);
        chk("t5_issrd", {28'b0, bus.iss_rd}, 32'd7);
        set_dec(7, 7, 0, 0, 1'b0, 6'b00_0011);
        #1 chk("t5_waw0", {31'b0, bus.dec_ready}, 32'd0);
        cyc();
        chk("t5_waw1", {31'b0, bus.dec_ready}, 32'd0);
        set_wb(7, 16'h1111);
        #1 chk("t5_waw_release", {31'b0, bus.dec_ready}, 32'd1);
        cyc();
        idle();
        chk("t5_op0_fwd", {16'b0, bus.op0}, 32'h1111);
        chk("t5_op1b",    {16'b0, bus.op1}, 32'h0003);
        do_wb(7, 16'h0);

        // 6: set beats clear, then reset mid-stall clears everything
        set_dec(1, 3, 2, 0, 1'b0, 6'd0);
        set_wb(3, 16'h5555);
        #1 chk("t6_ready", {31'b0, bus.dec_ready}, 32'd1);
        cyc();
        idle();
        set_dec(1, 11, 3, 0, 1'b0, 6'd0);
        #1 chk("t6_sb_set0", {31'b0, bus.dec_ready}, 32'd0);
        cyc();
        chk("t6_sb_set1", {31'b0, bus.dec_ready}, 32'd0);
        n_rst = 1'b0;
        #1 chk("t6_rst_ready", {31'b0, bus.dec_ready}, 32'd0);
        cyc();
        chk("t6_rst_valid", {31'b0, bus.iss_valid}, 32'd0);
        n_rst = 1'b1;
        #1 chk("t6_post_ready", {31'b0, bus.dec_ready}, 32'd1);
        cyc();
        idle();
        chk("t6_post_op0",   {16'b0, bus.op0},    32'h0);
        chk("t6_post_issrd", {28'b0, bus.iss_rd}, 32'd11);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            n_rst           = ($urandom_range(0, 149) != 0);
            bus.dec_valid   = ($urandom_range(0, 9) < 7);
            bus.dec_op      = 3'($urandom_range(0, 7));
            bus.dec_rd      = 4'($urandom_range(0, 15));
            bus.dec_rs_a    = 4'($urandom_range(0, 15));
            bus.dec_rs_b    = 4'($urandom_range(0, 15));
            bus.dec_use_imm = 1'($urandom_range(0, 1));
            bus.dec_imm     = 6'($urandom_range(0, 63));
            bus.iss_ready   = ($urandom_range(0, 9) < 7);
            bus.wb_valid    = ($urandom_range(0, 9) < 5);
            bus.wb_rd       = 4'($urandom_range(0, 15));
            bus.wb_data     = 16'($urandom);
            cyc();
        end

        n_rst = 1'b1;
        idle();
        cyc();
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
